// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle MIPS controller.
// Build option: JUMP_EN adds the JUMP state (opcode 000010 executes as j);
// without it, that opcode is treated as illegal.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_ILLEGAL  = 4'd12
`ifdef JUMP_EN
        , S_JUMP   = 4'd13
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // State-decoded control word. 'fetch' marks FETCH, where ir_write and
    // pc_write are additionally gated by the live mem_ready handshake.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       fetch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    // Moore output decode: every field not set for a state stays 0.
    function automatic ctrl_t decode_outputs(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.iord      = 1'b0;
                c.alu_src_a = 1'b0;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_RT;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
            end
`ifdef JUMP_EN
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
`endif
            S_ILLEGAL: begin
                c.illegal_op = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore sequencing controller for the multicycle MIPS datapath.
// Build option: JUMP_EN enables the JUMP state for opcode 000010.
// Control outputs are registered from the next state, so they are a pure
// function of the current state; only ir_write/pc_write in FETCH also follow
// mem_ready.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_source,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        illegal_op,
    output logic [31:0] instr_count
);

    state_t      state_r;
    state_t      next_state_s;
    logic        is_store_r;
    ctrl_t       ctrl_r;
    ctrl_t       ctrl_s;
    logic        retire_s;
    logic [31:0] instr_count_r;

    // Next-state selection; mem_ready only matters in the three memory-wait states.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_START:    next_state_s = S_FETCH;
            S_FETCH: begin
                if (mem_ready) next_state_s = S_DECODE;
                else           next_state_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state_s = S_EXEC;
                    OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_ADDI:      next_state_s = S_ADDI_EX;
`ifdef JUMP_EN
                    OP_J:         next_state_s = S_JUMP;
`endif
                    default:      next_state_s = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                if (is_store_r) next_state_s = S_MEM_WR;
                else            next_state_s = S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready) next_state_s = S_MEM_WB;
                else           next_state_s = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (mem_ready) next_state_s = S_FETCH;
                else           next_state_s = S_MEM_WR;
            end
            S_MEM_WB:   next_state_s = S_FETCH;
            S_EXEC:     next_state_s = S_R_WB;
            S_R_WB:     next_state_s = S_FETCH;
            S_BRANCH:   next_state_s = S_FETCH;
            S_ADDI_EX:  next_state_s = S_ADDI_WB;
            S_ADDI_WB:  next_state_s = S_FETCH;
`ifdef JUMP_EN
            S_JUMP:     next_state_s = S_FETCH;
`endif
            S_ILLEGAL:  next_state_s = S_FETCH;
            default:    next_state_s = S_START;
        endcase
    end

    // Control word for the state being entered, plus retire detection
    // (last cycle of a completed instruction that is about to return to FETCH).
    always_comb begin
        ctrl_s   = decode_outputs(next_state_s);
        retire_s = 1'b0;
        case (state_r)
            S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB: retire_s = 1'b1;
`ifdef JUMP_EN
            S_JUMP:                                retire_s = 1'b1;
`endif
            S_MEM_WR:                              retire_s = mem_ready;
            default:                               retire_s = 1'b0;
        endcase
    end

    // State register, registered control word and lw/sw flag captured in DECODE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_START;
            ctrl_r     <= '0;
            is_store_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_s;
            if (state_r == S_DECODE) begin
                is_store_r <= (opcode == OP_SW);
            end else begin
                is_store_r <= is_store_r;
            end
        end
    end

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_count_r <= 32'd0;
        end else if (retire_s) begin
            instr_count_r <= instr_count_r + 32'd1;
        end else begin
            instr_count_r <= instr_count_r;
        end
    end

    assign pc_write      = ctrl_r.pc_write | (ctrl_r.fetch & mem_ready);
    assign ir_write      = ctrl_r.fetch & mem_ready;
    assign pc_write_cond = ctrl_r.pc_write_cond;
    assign pc_source     = ctrl_r.pc_source;
    assign iord          = ctrl_r.iord;
    assign mem_read      = ctrl_r.mem_read;
    assign mem_write     = ctrl_r.mem_write;
    assign reg_dst       = ctrl_r.reg_dst;
    assign mem_to_reg    = ctrl_r.mem_to_reg;
    assign reg_write     = ctrl_r.reg_write;
    assign alu_src_a     = ctrl_r.alu_src_a;
    assign alu_src_b     = ctrl_r.alu_src_b;
    assign alu_op        = ctrl_r.alu_op;
    assign illegal_op    = ctrl_r.illegal_op;
    assign instr_count   = instr_count_r;

endmodule
